// File: rtl/distance_display_pkg.sv
// Shared types and segment tables for the multiplexed seven-segment distance display.
package distance_display_pkg;

   typedef enum logic {RUN, END} disp_state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   // Active-low gfedcba patterns; codes 10..15 are not BCD and show a dash.
   localparam logic [6:0] bcd_to_seg [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH
   };

endpackage

// File: rtl/distance_display_seg7_decode.sv
// Combinational 4-bit value to active-low seven-segment pattern.
module seg7_decode
   import distance_display_pkg::*;
(
   input  logic [3:0] value_i,
   output logic [6:0] seg_n_o
);

   assign seg_n_o = bcd_to_seg[value_i];

endmodule

// File: rtl/distance_display.sv
// Scans four snapshotted BCD digits onto a multiplexed active-low display,
// with leading-zero blanking and a blinking "0" once the distance runs out.
//
// state | meaning
// RUN   | show frame snapshot, leading zeros blanked, non-BCD as dash
// END   | distance exhausted: lone "0" on units, blinking per BLINK_FRAMES
module distance_display
   import distance_display_pkg::*;
#(
   parameter int SCAN_DIV     = 50000,
   parameter int BLINK_FRAMES = 125
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] thousands,
   input  logic [3:0] hundreds,
   input  logic [3:0] tens,
   input  logic [3:0] units,
   input  logic       dist_end,
   input  logic       restart_enable,
   output logic [6:0] seg_n,
   output logic [3:0] an_n,
   output logic       frame_start
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int BW = $clog2(BLINK_FRAMES + 1);
   localparam logic [PW-1:0] PS_LAST    = PW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

   logic [PW-1:0]      presc_q, presc_d;
   logic [1:0]         idx_q, idx_d;
   logic [3:0][3:0]    snap_q, snap_d;
   disp_state_t        state_q, state_d;
   logic               hide_q, hide_d;
   logic [BW-1:0]      blink_cnt_q, blink_cnt_d;
   logic [6:0]         seg_n_q, seg_n_d;
   logic [3:0]         an_n_q, an_n_d;
   logic               frame_start_q, frame_start_d;

   logic               tick;
   logic               wrap;
   logic [3:0]         blank;
   logic [3:0]         digit;
   logic [6:0]         digit_seg;

   assign tick = (presc_q == PS_LAST);
   assign wrap = tick && (idx_q == 2'd3);

   seg7_decode u_dec (
      .value_i (digit),
      .seg_n_o (digit_seg)
   );

   // Display uses the snapshot as it will be after this edge, so the units
   // slot that opens a frame already shows the freshly loaded digits.
   assign digit = snap_d[idx_d];

   always_comb begin
      blank[0] = 1'b0;
      blank[3] = (snap_d[3] == 4'd0);
      blank[2] = blank[3] && (snap_d[2] == 4'd0);
      blank[1] = blank[2] && (snap_d[1] == 4'd0);
   end

   always_comb begin
      presc_d       = tick ? '0 : presc_q + PW'(1);
      idx_d         = tick ? idx_q + 2'd1 : idx_q;
      frame_start_d = wrap;
      state_d       = state_q;
      hide_d        = hide_q;
      blink_cnt_d   = blink_cnt_q;
      snap_d        = snap_q;
      seg_n_d       = seg_n_q;
      an_n_d        = an_n_q;

      if (wrap && (state_q == RUN))
         snap_d = {thousands, hundreds, tens, units};

      case (state_q)
         RUN: begin
            if (dist_end && !restart_enable)
               state_d = END;
         end
         END: begin
            if (restart_enable || !dist_end) begin
               state_d     = RUN;
               hide_d      = 1'b0;
               blink_cnt_d = '0;
            end else if (wrap) begin
               if (blink_cnt_q == BLINK_LAST) begin
                  blink_cnt_d = '0;
                  hide_d      = !hide_q;
               end else begin
                  blink_cnt_d = blink_cnt_q + BW'(1);
               end
            end
         end
         default: state_d = RUN;
      endcase

      if (tick) begin
         seg_n_d = SEG_BLANK;
         an_n_d  = 4'hF;
         if (state_q == RUN) begin
            if (!blank[idx_d]) begin
               seg_n_d = digit_seg;
               an_n_d  = ~(4'b0001 << idx_d);
            end
         end else if (!hide_q && (idx_d == 2'd0)) begin
            seg_n_d = bcd_to_seg[0];
            an_n_d  = 4'b1110;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q       <= '0;
         idx_q         <= 2'd0;
         snap_q        <= '0;
         state_q       <= RUN;
         hide_q        <= 1'b0;
         blink_cnt_q   <= '0;
         seg_n_q       <= SEG_BLANK;
         an_n_q        <= 4'hF;
         frame_start_q <= 1'b0;
      end else begin
         presc_q       <= presc_d;
         idx_q         <= idx_d;
         snap_q        <= snap_d;
         state_q       <= state_d;
         hide_q        <= hide_d;
         blink_cnt_q   <= blink_cnt_d;
         seg_n_q       <= seg_n_d;
         an_n_q        <= an_n_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign seg_n       = seg_n_q;
   assign an_n        = an_n_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_distance_display.sv
// Directed bench for distance_display with SCAN_DIV=4, BLINK_FRAMES=2.
module tb_distance_display;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] thousands = 4'd0, hundreds = 4'd0, tens = 4'd0, units = 4'd0;
   logic       dist_end = 1'b0;
   logic       restart_enable = 1'b0;
   logic [6:0] seg_n;
   logic [3:0] an_n;
   logic       frame_start;

   int errors = 0;
   int checks = 0;

   distance_display #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
      .clk            (clk),
      .reset          (reset),
      .thousands      (thousands),
      .hundreds       (hundreds),
      .tens           (tens),
      .units          (units),
      .dist_end       (dist_end),
      .restart_enable (restart_enable),
      .seg_n          (seg_n),
      .an_n           (an_n),
      .frame_start    (frame_start)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic next_slot();
      repeat (4) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      {thousands, hundreds, tens, units} = 16'h1000;
      repeat (3) @(negedge clk);
      checks++; if (seg_n !== 7'h7F) begin errors++; $display("FAIL reset_seg got %b want %b", seg_n, 7'h7F); end
      checks++; if (an_n !== 4'hF) begin errors++; $display("FAIL reset_an got %b want %b", an_n, 4'hF); end
      checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs got %b want 0", frame_start); end
      reset = 1'b0;
      for (int s = 1; s < 4; s++) begin
         next_slot();
         checks++; if (an_n !== 4'hF || seg_n !== 7'h7F || frame_start !== 1'b0) begin
            errors++; $display("FAIL first_frame slot%0d got an=%b seg=%b fs=%b want an=1111 seg=1111111 fs=0", s, an_n, seg_n, frame_start);
         end
      end
   endtask

   task automatic test_thousand();
      logic [3:0] ea [4];
      logic [6:0] es [4];
      ea = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      es = '{7'b1000000, 7'b1000000, 7'b1000000, 7'b1111001};
      for (int f = 0; f < 2; f++) begin
         for (int s = 0; s < 4; s++) begin
            next_slot();
            checks++; if (an_n !== ea[s] || seg_n !== es[s] || frame_start !== (s == 0)) begin
               errors++; $display("FAIL thousand f%0d slot%0d got an=%b seg=%b fs=%b want an=%b seg=%b fs=%b", f, s, an_n, seg_n, frame_start, ea[s], es[s], (s == 0));
            end
         end
      end
   endtask

   task automatic test_frame_start();
      int cnt = 0;
      repeat (32) begin
         @(negedge clk);
         if (frame_start === 1'b1) cnt++;
      end
      checks++; if (cnt !== 2) begin errors++; $display("FAIL frame_start_count got %0d want 2", cnt); end
   endtask

   task automatic test_blanking();
      logic [3:0] ea [4];
      logic [6:0] es [4];
      {thousands, hundreds, tens, units} = 16'h0042;
      ea = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
      es = '{7'b0100100, 7'b0011001, 7'h7F, 7'h7F};
      for (int s = 0; s < 4; s++) begin
         next_slot();
         checks++; if (an_n !== ea[s] || seg_n !== es[s]) begin
            errors++; $display("FAIL blanking slot%0d got an=%b seg=%b want an=%b seg=%b", s, an_n, seg_n, ea[s], es[s]);
         end
      end
   endtask

   task automatic test_invalid();
      logic [3:0] ea [4];
      logic [6:0] es [4];
      {thousands, hundreds, tens, units} = 16'h0C05;
      ea = '{4'b1110, 4'b1101, 4'b1011, 4'b1111};
      es = '{7'b0010010, 7'b1000000, 7'b0111111, 7'h7F};
      for (int s = 0; s < 4; s++) begin
         next_slot();
         checks++; if (an_n !== ea[s] || seg_n !== es[s]) begin
            errors++; $display("FAIL invalid slot%0d got an=%b seg=%b want an=%b seg=%b", s, an_n, seg_n, ea[s], es[s]);
         end
      end
   endtask

   task automatic test_no_tear();
      logic [3:0] ea [4];
      logic [6:0] es [12];
      {thousands, hundreds, tens, units} = 16'h0999;
      ea = '{4'b1110, 4'b1101, 4'b1011, 4'b1111};
      es = '{7'b0010000, 7'b0010000, 7'b0010000, 7'h7F,
             7'b0000000, 7'b0010000, 7'b0010000, 7'h7F,
             7'b1111000, 7'b1111000, 7'b1111000, 7'h7F};
      for (int f = 0; f < 3; f++) begin
         for (int s = 0; s < 4; s++) begin
            next_slot();
            checks++; if (an_n !== ea[s] || seg_n !== es[f*4+s]) begin
               errors++; $display("FAIL no_tear f%0d slot%0d got an=%b seg=%b want an=%b seg=%b", f, s, an_n, seg_n, ea[s], es[f*4+s]);
            end
            if (s == 1 && f == 0) units = 4'd8;
            if (s == 1 && f == 1) {thousands, hundreds, tens, units} = 16'h0777;
         end
      end
   endtask

   task automatic test_restart_priority();
      logic [3:0] ea [4];
      dist_end = 1'b1;
      restart_enable = 1'b1;
      ea = '{4'b1110, 4'b1101, 4'b1011, 4'b1111};
      for (int s = 0; s < 4; s++) begin
         next_slot();
         checks++; if (an_n !== ea[s] || seg_n !== ((s == 3) ? 7'h7F : 7'b1111000)) begin
            errors++; $display("FAIL restart_priority slot%0d got an=%b seg=%b want an=%b", s, an_n, seg_n, ea[s]);
         end
      end
   endtask

   task automatic test_end_blink();
      logic vis [5];
      logic [3:0] ea [4];
      logic [6:0] es [4];
      vis = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      restart_enable = 1'b0;
      {thousands, hundreds, tens, units} = 16'h1234;
      for (int f = 0; f < 5; f++) begin
         for (int s = 0; s < 4; s++) begin
            next_slot();
            checks++;
            if (s == 0 && vis[f]) begin
               if (an_n !== 4'b1110 || seg_n !== 7'b1000000 || frame_start !== 1'b1) begin
                  errors++; $display("FAIL end_blink f%0d slot0 got an=%b seg=%b fs=%b want an=1110 seg=1000000 fs=1", f, an_n, seg_n, frame_start);
               end
            end else if (an_n !== 4'hF || seg_n !== 7'h7F || frame_start !== (s == 0)) begin
               errors++; $display("FAIL end_blink f%0d slot%0d got an=%b seg=%b fs=%b want dark fs=%b", f, s, an_n, seg_n, frame_start, (s == 0));
            end
         end
      end
      restart_enable = 1'b1;
      dist_end = 1'b0;
      @(negedge clk);
      restart_enable = 1'b0;
      repeat (3) @(negedge clk);
      ea = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      es = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
      for (int s = 0; s < 4; s++) begin
         if (s != 0) next_slot();
         checks++; if (an_n !== ea[s] || seg_n !== es[s] || frame_start !== (s == 0)) begin
            errors++; $display("FAIL after_restart slot%0d got an=%b seg=%b fs=%b want an=%b seg=%b", s, an_n, seg_n, frame_start, ea[s], es[s]);
         end
      end
   endtask

   task automatic test_reset_mid_blink();
      dist_end = 1'b1;
      next_slot();
      checks++; if (an_n !== 4'b1110 || seg_n !== 7'b1000000) begin
         errors++; $display("FAIL blink_visible got an=%b seg=%b want an=1110 seg=1000000", an_n, seg_n);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      dist_end = 1'b0;
      checks++; if (seg_n !== 7'h7F || an_n !== 4'hF || frame_start !== 1'b0) begin
         errors++; $display("FAIL mid_reset got an=%b seg=%b fs=%b want an=1111 seg=1111111 fs=0", an_n, seg_n, frame_start);
      end
      repeat (15) @(negedge clk);
      checks++; if (frame_start !== 1'b0 || an_n !== 4'hF) begin
         errors++; $display("FAIL post_reset_c15 got an=%b fs=%b want an=1111 fs=0", an_n, frame_start);
      end
      @(negedge clk);
      checks++; if (frame_start !== 1'b1 || an_n !== 4'b1110 || seg_n !== 7'b0011001) begin
         errors++; $display("FAIL post_reset_wrap got an=%b seg=%b fs=%b want an=1110 seg=0011001 fs=1", an_n, seg_n, frame_start);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_thousand();
      test_frame_start();
      test_blanking();
      test_invalid();
      test_no_tear();
      test_restart_priority();
      test_end_blink();
      test_reset_mid_blink();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
